// File: rtl/codificador_sensores_if.sv
// Report bus of the sensor encoder: snapshot outputs plus the consumer acknowledge.
interface codificador_sensores_if;
   logic       Valido;
   logic [3:0] Vector;
   logic [1:0] Codigo;
   logic       Activo;
   logic       ACK;

   modport master (output Valido, output Vector, output Codigo, output Activo, input ACK);
   modport slave  (input Valido, input Vector, input Codigo, input Activo, output ACK);
endinterface

// File: rtl/codificador_sensores.sv
// Sensor encoder: synchronizes and debounces four alarm lines, then publishes
// one report at a time (vector, priority code, any-active) over a valid/ack bus.
module codificador_sensores #(
   parameter int unsigned DEB_CYCLES = 4
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic                    Temperatura,
   input  logic                    Humo,
   input  logic                    SobreCarga,
   input  logic                    Manual,
   codificador_sensores_if.master  rep
);

   localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

   typedef enum logic {IDLE, PEND} state_t;

   logic [3:0]      raw;
   logic [3:0]      sync1_q, sync2_q;
   logic [3:0]      deb_q, deb_d;
   logic [3:0][7:0] cnt_q, cnt_d;
   state_t          state_q, state_d;
   logic [3:0]      ultimo_q, ultimo_d;
   logic [3:0]      vector_q, vector_d;
   logic [1:0]      codigo_q, codigo_d;
   logic            activo_q, activo_d;

   assign raw = {Humo, Temperatura, SobreCarga, Manual};

   function automatic logic [1:0] prio(input logic [3:0] v);
      if (v[3])      prio = 2'd3;
      else if (v[2]) prio = 2'd2;
      else if (v[1]) prio = 2'd1;
      else           prio = 2'd0;
   endfunction

   // Two-flop synchronizer on every raw line.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
      end
   end

   // Per-bit debounce: count consecutive disagreeing cycles, adopt the new level on the last one.
   always_comb begin
      deb_d = deb_q;
      cnt_d = cnt_q;
      for (int unsigned i = 0; i < 4; i++) begin
         if (sync2_q[i] == deb_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == DEB_LAST) begin
            deb_d[i] = sync2_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + 8'd1;
         end
      end
   end

   // Debounce state registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         deb_q <= '0;
         cnt_q <= '0;
      end else begin
         deb_q <= deb_d;
         cnt_q <= cnt_d;
      end
   end

   // Report FSM: snapshot on a difference from the last report, hold until acknowledged.
   always_comb begin
      state_d  = state_q;
      ultimo_d = ultimo_q;
      vector_d = vector_q;
      codigo_d = codigo_q;
      activo_d = activo_q;
      case (state_q)
         IDLE: begin
            if (deb_q != ultimo_q) begin
               state_d  = PEND;
               ultimo_d = deb_q;
               vector_d = deb_q;
               codigo_d = prio(deb_q);
               activo_d = |deb_q;
            end
         end
         PEND: begin
            if (rep.ACK) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Report FSM and snapshot registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= IDLE;
         ultimo_q <= '0;
         vector_q <= '0;
         codigo_q <= '0;
         activo_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ultimo_q <= ultimo_d;
         vector_q <= vector_d;
         codigo_q <= codigo_d;
         activo_q <= activo_d;
      end
   end

   assign rep.Valido = (state_q == PEND);
   assign rep.Vector = vector_q;
   assign rep.Codigo = codigo_q;
   assign rep.Activo = activo_q;

endmodule

// File: tb/tb_codificador_sensores.sv
// Directed bench for codificador_sensores with DEB_CYCLES=4 (raw-to-Valido = 7 edges).
module tb_codificador_sensores;

   logic CLK;
   logic RST_N;
   logic Temperatura, Humo, SobreCarga, Manual;
   int   errors = 0;
   int   checks = 0;

   codificador_sensores_if bus ();

   codificador_sensores #(.DEB_CYCLES(4)) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .Temperatura (Temperatura),
      .Humo        (Humo),
      .SobreCarga  (SobreCarga),
      .Manual      (Manual),
      .rep         (bus.master)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [3:0] vec,
                          input logic [1:0] cod, input logic act);
      check({tag, ".Valido"}, {7'd0, bus.Valido}, {7'd0, v});
      check({tag, ".Vector"}, {4'd0, bus.Vector}, {4'd0, vec});
      check({tag, ".Codigo"}, {6'd0, bus.Codigo}, {6'd0, cod});
      check({tag, ".Activo"}, {7'd0, bus.Activo}, {7'd0, act});
   endtask

   // Advance n rising edges and settle just past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic ack_pulse(input string tag);
      bus.ACK = 1'b1;
      tick(1);
      check({tag, ".ack_drop"}, {7'd0, bus.Valido}, 8'd0);
      bus.ACK = 1'b0;
   endtask

   initial begin
      RST_N = 1'b0;
      Temperatura = 1'b0; Humo = 1'b0; SobreCarga = 1'b0; Manual = 1'b0;
      bus.ACK = 1'b0;

      // Reset state
      tick(2);
      chk_out("reset", 1'b0, 4'b0000, 2'd0, 1'b0);
      RST_N = 1'b1;
      tick(2);
      chk_out("post_reset", 1'b0, 4'b0000, 2'd0, 1'b0);

      // Single input: Humo, report at edge 7
      Humo = 1'b1;
      tick(6);
      check("humo.edge6", {7'd0, bus.Valido}, 8'd0);
      tick(1);
      chk_out("humo.edge7", 1'b1, 4'b1000, 2'd3, 1'b1);

      // Change during PEND: Manual raised, ACK held low for 20 cycles
      Manual = 1'b1;
      tick(20);
      chk_out("pend_hold", 1'b1, 4'b1000, 2'd3, 1'b1);
      bus.ACK = 1'b1;
      tick(1);
      check("pend.ack_valido", {7'd0, bus.Valido}, 8'd0);
      check("pend.ack_vector", {4'd0, bus.Vector}, 8'h08);
      bus.ACK = 1'b0;
      tick(1);
      chk_out("pend_new", 1'b1, 4'b1001, 2'd3, 1'b1);
      ack_pulse("pend_new");

      // Both lines drop together: all-clear report
      Humo = 1'b0; Manual = 1'b0;
      tick(6);
      check("clear1.edge6", {7'd0, bus.Valido}, 8'd0);
      tick(1);
      chk_out("clear1", 1'b1, 4'b0000, 2'd0, 1'b0);
      ack_pulse("clear1");

      // Glitch of 3 cycles on Temperatura is rejected
      Temperatura = 1'b1;
      tick(3);
      Temperatura = 1'b0;
      tick(20);
      check("glitch.valido", {7'd0, bus.Valido}, 8'd0);
      check("glitch.vector", {4'd0, bus.Vector}, 8'd0);

      // ACK in IDLE is ignored
      bus.ACK = 1'b1;
      tick(5);
      check("ack_idle", {7'd0, bus.Valido}, 8'd0);
      bus.ACK = 1'b0;

      // Priority: Manual and SobreCarga together -> one report
      Manual = 1'b1; SobreCarga = 1'b1;
      tick(7);
      chk_out("prio", 1'b1, 4'b0011, 2'd1, 1'b1);
      tick(3);
      check("prio.held", {7'd0, bus.Valido}, 8'd1);
      ack_pulse("prio");
      tick(3);
      check("prio.single", {7'd0, bus.Valido}, 8'd0);

      // 0011 -> 0100 in one step, then all-clear from 0100
      Manual = 1'b0; SobreCarga = 1'b0; Temperatura = 1'b1;
      tick(7);
      chk_out("temp", 1'b1, 4'b0100, 2'd2, 1'b1);
      ack_pulse("temp");
      Temperatura = 1'b0;
      tick(6);
      check("clear2.edge6", {7'd0, bus.Valido}, 8'd0);
      tick(1);
      chk_out("clear2", 1'b1, 4'b0000, 2'd0, 1'b0);
      ack_pulse("clear2");

      // Change that returns to the last report before ACK -> no new report
      Humo = 1'b1;
      tick(7);
      chk_out("ret", 1'b1, 4'b1000, 2'd3, 1'b1);
      Manual = 1'b1;
      tick(10);
      Manual = 1'b0;
      tick(10);
      ack_pulse("ret");
      tick(3);
      check("ret.no_report", {7'd0, bus.Valido}, 8'd0);
      check("ret.vector", {4'd0, bus.Vector}, 8'h08);

      // Reset asserted during PEND
      Humo = 1'b0;
      tick(7);
      chk_out("humo_off", 1'b1, 4'b0000, 2'd0, 1'b0);
      ack_pulse("humo_off");
      Temperatura = 1'b1;
      tick(7);
      chk_out("pre_rst", 1'b1, 4'b0100, 2'd2, 1'b1);
      RST_N = 1'b0;
      #1;
      chk_out("rst_pend", 1'b0, 4'b0000, 2'd0, 1'b0);
      Temperatura = 1'b0;
      tick(2);
      RST_N = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick(1);
         check("rst_quiet", {7'd0, bus.Valido}, 8'd0);
      end
      check("rst_quiet.vector", {4'd0, bus.Vector}, 8'd0);

      // Input held high through reset is reported 7 edges after release
      RST_N = 1'b0;
      Humo = 1'b1;
      tick(3);
      chk_out("rst_hold.in_reset", 1'b0, 4'b0000, 2'd0, 1'b0);
      RST_N = 1'b1;
      tick(6);
      check("rst_hold.edge6", {7'd0, bus.Valido}, 8'd0);
      tick(1);
      chk_out("rst_hold.edge7", 1'b1, 4'b1000, 2'd3, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/codificador_sensores.md
CODIFICADOR_SENSORES -- requirements
Module: codificador_sensores

Interface
REQ-001 The module SHALL have parameter DEB_CYCLES, default 4, meaning the number of consecutive cycles a synchronized input must differ from its debounced value before that value updates (legal range 1..255).
REQ-002 The module SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The module SHALL have ports Temperatura, Humo, SobreCarga and Manual, each input, 1 bit: raw asynchronous sensor and switch lines, active-high.
REQ-005 The module SHALL have port ACK, input, 1 bit: consumer acknowledge of the current report.
REQ-006 The module SHALL have port Valido, output, 1 bit: a report is pending.
REQ-007 The module SHALL have port Vector, output, 4 bits: debounced snapshot ordered {Humo, Temperatura, SobreCarga, Manual}, MSB first.
REQ-008 The module SHALL have port Codigo, output, 2 bits: priority code of the highest active bit in Vector (Humo=3, Temperatura=2, SobreCarga=1, Manual=0).
REQ-009 The module SHALL have port Activo, output, 1 bit: OR-reduction of Vector.

Function
REQ-010 Each raw input SHALL pass through a two-flop synchronizer before any other logic.
REQ-011 Each synchronized bit SHALL have its own debounce counter, sized to count to DEB_CYCLES.
- Counter clears whenever the synchronized bit equals the debounced bit.
- Counter increments when the bits differ.
- When the counter would reach DEB_CYCLES, the debounced bit takes the synchronized value and the counter clears.
REQ-012 A raw input change held stable SHALL update its debounced bit at rising edge DEB_CYCLES+2, counted from the first edge that samples the new value.
REQ-013 A glitch shorter than DEB_CYCLES synchronized cycles SHALL NOT change the debounced bit.
REQ-014 Report control SHALL be a two-state FSM, IDLE and PEND, and SHALL keep a register Ultimo holding the last reported debounced vector.
REQ-015 In IDLE, when the debounced vector differs from Ultimo:
- Vector, Codigo, Activo and Ultimo SHALL load from the debounced vector on that edge.
- The FSM SHALL enter PEND, so Valido rises one edge after the debounced update.
- Total raw-to-Valido latency SHALL be DEB_CYCLES+3 edges.
REQ-016 In PEND, Valido SHALL be 1, and Vector, Codigo and Activo SHALL hold stable regardless of further input changes.
REQ-017 In PEND, when ACK=1 is sampled, the FSM SHALL return to IDLE and Valido SHALL drop on that edge.
REQ-018 Debounced changes that occur during PEND SHALL NOT be lost.
- After ACK, IDLE compares against Ultimo on the next edge.
- If the vector differs, a new report SHALL issue with Valido low for exactly one cycle.
- Only the latest debounced value SHALL be reported; intermediate values SHALL NOT be queued.
REQ-019 A change that returns to the Ultimo value before ACK SHALL produce no new report.
REQ-020 ACK sampled in IDLE SHALL be ignored.
REQ-021 When Vector=0, Codigo SHALL be 0 and Activo SHALL be 0; an all-clear transition SHALL be reported like any other change.
REQ-022 Simultaneous debounced changes on several bits at the same edge SHALL produce exactly one report containing all of them.

Reset
REQ-023 While RST_N=0, the following SHALL clear asynchronously to 0: synchronizers, debounced bits, counters, Ultimo, Vector, Codigo, Activo and Valido. The FSM SHALL go to IDLE.
REQ-024 Deassertion of RST_N SHALL take effect at the next rising CLK edge.
REQ-025 Inputs held high through reset SHALL be reported after DEB_CYCLES+3 edges following deassertion.
REQ-026 Reset asserted during PEND SHALL drop the pending report with no later re-report, except as required by REQ-025.

Verification
REQ-027 The bench SHALL cover single input: with DEB_CYCLES=4, raise Humo and hold -> Valido=1 at edge 7, Vector=1000, Codigo=3, Activo=1; ACK=1 for one cycle -> Valido=0 on the next edge.
REQ-028 The bench SHALL cover glitch rejection: pulse Temperatura for 3 cycles -> Valido stays 0 and Vector stays 0000.
REQ-029 The bench SHALL cover priority: raise Manual and SobreCarga on the same cycle -> one report with Vector=0011, Codigo=1.
REQ-030 The bench SHALL cover change during PEND: with a Humo report pending, raise Manual and hold ACK low for 20 cycles -> Vector stays 1000; then ACK -> Valido low for one cycle, then Vector=1001, Codigo=3.
REQ-031 The bench SHALL cover all-clear: after Vector=0100 is acknowledged, drop Temperatura -> report with Vector=0000, Codigo=0, Activo=0.
REQ-032 The bench SHALL cover reset mid-PEND: assert RST_N=0 while Valido=1 -> all outputs 0 immediately; release with all inputs low -> no report for 50 cycles.
